// File: rtl/udp_payload_arb.sv
// Packet-granular arbiter that shares one AXI-Stream payload path between NUM_IN sources.
// A source that stalls mid-packet is aborted (tuser-flagged final beat) and its remainder drained.
//
// state | meaning
// IDLE  | no packet in flight; pick a winner, one-cycle bubble
// PASS  | granted stream passes straight through to the sink
// ABORT | stalled source; emit a tlast+tuser drop beat to the sink
// DRAIN | swallow the aborted source's remaining beats up to its tlast
module udp_payload_arb #(
  parameter int NUM_IN      = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 1024,
  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_IN-1:0]            s_axis_tvalid,
  output logic [NUM_IN-1:0]            s_axis_tready,
  input  logic [NUM_IN-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic [GW-1:0]                grant_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_ABORT, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            timeout_q, timeout_d;
  logic [GW-1:0]   win;
  logic            win_vld;
  logic [DATA_WIDTH-1:0] sel_data;
  logic            sel_valid;
  logic            sel_last;

  assign sel_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];

  // Descending loops: the last hit written is the first one in search order.
  always_comb begin
    int idx;
    win     = grant_q;
    win_vld = 1'b0;
    idx     = 0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (s_axis_tvalid[i]) begin
          win     = GW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        idx = (int'(grant_q) + k) % NUM_IN;
        if (s_axis_tvalid[idx]) begin
          win     = GW'(idx);
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    stall_d       = stall_q;
    timeout_d     = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = win;
          stall_d = '0;
          state_d = S_PASS;
        end
      end
      S_PASS: begin
        m_axis_tdata           = sel_data;
        m_axis_tvalid          = sel_valid;
        m_axis_tlast           = sel_last;
        s_axis_tready[grant_q] = m_axis_tready;
        if (sel_valid && m_axis_tready) begin
          stall_d = '0;
          if (sel_last) state_d = S_IDLE;
        end else if (!sel_valid) begin
          if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
          // Only a silent source counts; a stalled sink holds the counter.
          if (TIMEOUT_CYC != 0 && stall_q != STALL_MAX && stall_d == STALL_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        // A delivered tlast always leaves PASS directly, so an aborted source still owes one.
        if (m_axis_tready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        s_axis_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= GW'(NUM_IN - 1);
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != S_IDLE);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_udp_payload_arb.sv
// Directed bench for udp_payload_arb: vector table plus hand sequences for
// round-robin, fixed priority, stall abort and mid-packet reset.
module tb_udp_payload_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic        grant_o, busy_o, timeout_o;

  logic [15:0] fp_s_tdata;
  logic [1:0]  fp_s_tvalid, fp_s_tready, fp_s_tlast;
  logic [7:0]  fp_m_tdata;
  logic        fp_m_tvalid, fp_m_tready, fp_m_tlast, fp_m_tuser;
  logic        fp_grant, fp_busy, fp_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udp_payload_arb #(.NUM_IN(2), .DATA_WIDTH(8), .ARB_MODE(0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  udp_payload_arb #(.NUM_IN(2), .DATA_WIDTH(8), .ARB_MODE(1), .TIMEOUT_CYC(0)) dut_fp (
    .clk(clk), .rst(rst),
    .s_axis_tdata(fp_s_tdata), .s_axis_tvalid(fp_s_tvalid),
    .s_axis_tready(fp_s_tready), .s_axis_tlast(fp_s_tlast),
    .m_axis_tdata(fp_m_tdata), .m_axis_tvalid(fp_m_tvalid),
    .m_axis_tready(fp_m_tready), .m_axis_tlast(fp_m_tlast),
    .m_axis_tuser(fp_m_tuser), .grant_o(fp_grant), .busy_o(fp_busy),
    .timeout_o(fp_timeout)
  );

  typedef struct {
    logic        r;
    logic [1:0]  vld, lst;
    logic [15:0] dat;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el, eu;
    logic [1:0]  esr;
    logic        eg, eb, et;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] vld, logic [1:0] lst, logic [15:0] dat,
                              logic rdy, logic ev, logic [7:0] ed, logic el, logic eu,
                              logic [1:0] esr, logic eg, logic eb, logic et);
    vec_t v;
    v.r = r; v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eu = eu; v.esr = esr;
    v.eg = eg; v.eb = eb; v.et = et;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input string nm, input int idx);
    rst           = v.r;
    s_axis_tvalid = v.vld;
    s_axis_tlast  = v.lst;
    s_axis_tdata  = v.dat;
    m_axis_tready = v.rdy;
    #1;
    chk({nm, ".tvalid"}, idx, 32'(m_axis_tvalid), 32'(v.ev));
    chk({nm, ".tdata"},  idx, 32'(m_axis_tdata),  32'(v.ed));
    chk({nm, ".tlast"},  idx, 32'(m_axis_tlast),  32'(v.el));
    chk({nm, ".tuser"},  idx, 32'(m_axis_tuser),  32'(v.eu));
    chk({nm, ".sready"}, idx, 32'(s_axis_tready), 32'(v.esr));
    chk({nm, ".grant"},  idx, 32'(grant_o),       32'(v.eg));
    chk({nm, ".busy"},   idx, 32'(busy_o),        32'(v.eb));
    chk({nm, ".timeout"},idx, 32'(timeout_o),     32'(v.et));
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    int sb[2];
    logic [7:0] ob[$];
    logic       olast[$];
    int pk, gaps, bad1, badd, n;

    // Packet through stream 0, then a backpressured packet through stream 1.
    tbl[0]  = mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0);
    tbl[1]  = mk(0, 2'b01, 2'b00, 16'h00A0, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0);
    tbl[2]  = mk(0, 2'b01, 2'b00, 16'h00A0, 1, 1, 8'hA0, 0, 0, 2'b01, 0, 1, 0);
    tbl[3]  = mk(0, 2'b01, 2'b00, 16'h00A1, 1, 1, 8'hA1, 0, 0, 2'b01, 0, 1, 0);
    tbl[4]  = mk(0, 2'b01, 2'b00, 16'h00A2, 1, 1, 8'hA2, 0, 0, 2'b01, 0, 1, 0);
    tbl[5]  = mk(0, 2'b01, 2'b01, 16'h00A3, 1, 1, 8'hA3, 1, 0, 2'b01, 0, 1, 0);
    tbl[6]  = mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tbl[7]  = mk(0, 2'b10, 2'b00, 16'hB000, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tbl[8]  = mk(0, 2'b10, 2'b00, 16'hB000, 1, 1, 8'hB0, 0, 0, 2'b10, 1, 1, 0);
    tbl[9]  = mk(0, 2'b10, 2'b00, 16'hB100, 0, 1, 8'hB1, 0, 0, 2'b00, 1, 1, 0);
    tbl[10] = mk(0, 2'b10, 2'b00, 16'hB100, 0, 1, 8'hB1, 0, 0, 2'b00, 1, 1, 0);
    tbl[11] = mk(0, 2'b10, 2'b00, 16'hB100, 1, 1, 8'hB1, 0, 0, 2'b10, 1, 1, 0);
    tbl[12] = mk(0, 2'b10, 2'b00, 16'hB200, 1, 1, 8'hB2, 0, 0, 2'b10, 1, 1, 0);
    tbl[13] = mk(0, 2'b10, 2'b00, 16'hB300, 1, 1, 8'hB3, 0, 0, 2'b10, 1, 1, 0);
    tbl[14] = mk(0, 2'b10, 2'b10, 16'hB400, 1, 1, 8'hB4, 1, 0, 2'b10, 1, 1, 0);
    tbl[15] = mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0);

    fp_s_tvalid = '0; fp_s_tlast = '0; fp_s_tdata = '0; fp_m_tready = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) apply(tbl[i], "tbl", i);

    // Round robin with both streams always offering 3-beat packets.
    sb[0] = 0; sb[1] = 0; pk = 0; gaps = 0;
    for (int c = 0; c < 60 && pk < 4; c++) begin
      s_axis_tvalid = 2'b11;
      s_axis_tdata  = {8'(8'h10 | sb[1]), 8'(sb[0])};
      s_axis_tlast  = {sb[1] == 2, sb[0] == 2};
      m_axis_tready = 1'b1;
      #1;
      if (m_axis_tvalid) begin
        ob.push_back(m_axis_tdata);
        olast.push_back(m_axis_tlast);
        if (m_axis_tlast) pk++;
      end else if (ob.size() > 0) gaps++;
      for (int s = 0; s < 2; s++) if (s_axis_tready[s]) sb[s] = (sb[s] + 1) % 3;
      step();
    end
    chk("rr_pkts", 0, 32'(pk), 32'd4);
    chk("rr_gaps", 0, 32'(gaps), 32'd3);
    chk("rr_beats", 0, 32'(ob.size()), 32'd12);
    n = (ob.size() < 12) ? ob.size() : 12;
    for (int j = 0; j < n; j++) begin
      chk("rr_data", j, 32'(ob[j]), 32'((((j / 3) % 2) << 4) | (j % 3)));
      chk("rr_last", j, 32'(olast[j]), 32'((j % 3) == 2));
    end
    s_axis_tvalid = '0; s_axis_tlast = '0;
    step();

    // Fixed priority: stream 0 should own the path.
    sb[0] = 0; sb[1] = 0; pk = 0; bad1 = 0; badd = 0;
    for (int c = 0; c < 24; c++) begin
      fp_s_tvalid = 2'b11;
      fp_s_tdata  = {8'(8'h10 | sb[1]), 8'(sb[0])};
      fp_s_tlast  = {sb[1] == 2, sb[0] == 2};
      fp_m_tready = 1'b1;
      #1;
      if (fp_s_tready[1]) bad1++;
      if (fp_m_tvalid) begin
        if (fp_m_tdata[7:4] != 4'h0) badd++;
        if (fp_m_tlast) pk++;
      end
      for (int s = 0; s < 2; s++) if (fp_s_tready[s]) sb[s] = (sb[s] + 1) % 3;
      step();
    end
    chk("fp_s1_ready", 0, 32'(bad1), 32'd0);
    chk("fp_s1_data", 0, 32'(badd), 32'd0);
    chk("fp_pkts", 0, 32'(pk), 32'd6);
    fp_s_tvalid = '0;

    // Stream 1 stalls mid-packet while stream 0 waits.
    do_reset();
    apply(mk(0, 2'b10, 2'b00, 16'hC000, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0), "to_pre", 0);
    apply(mk(0, 2'b10, 2'b00, 16'hC000, 1, 1, 8'hC0, 0, 0, 2'b10, 1, 1, 0), "to_pre", 1);
    apply(mk(0, 2'b10, 2'b00, 16'hC100, 1, 1, 8'hC1, 0, 0, 2'b10, 1, 1, 0), "to_pre", 2);
    for (int i = 0; i < 20; i++) begin
      if (i < 16)
        apply(mk(0, 2'b01, 2'b01, 16'h00D0, 1, 0, 8'h00, 0, 0, 2'b10, 1, 1, 0), "to_stall", i);
      else if (i == 16)
        apply(mk(0, 2'b01, 2'b01, 16'h00D0, 1, 1, 8'h00, 1, 1, 2'b00, 1, 1, 1), "to_stall", i);
      else
        apply(mk(0, 2'b01, 2'b01, 16'h00D0, 1, 0, 8'h00, 0, 0, 2'b10, 1, 1, 0), "to_stall", i);
    end
    for (int j = 0; j < 3; j++)
      apply(mk(0, 2'b11, {j == 2, 1'b1}, {8'(8'hE0 + j), 8'hD0}, 1, 0, 8'h00, 0, 0, 2'b10, 1, 1, 0),
            "to_drain", j);
    apply(mk(0, 2'b01, 2'b01, 16'h00D0, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0), "to_post", 0);
    apply(mk(0, 2'b01, 2'b01, 16'h00D0, 1, 1, 8'hD0, 1, 0, 2'b01, 0, 1, 0), "to_post", 1);
    apply(mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0), "to_post", 2);

    // Reset lands on beat 2 of a 6-beat packet.
    apply(mk(0, 2'b01, 2'b00, 16'h00F0, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0), "rst_seq", 0);
    apply(mk(0, 2'b01, 2'b00, 16'h00F0, 1, 1, 8'hF0, 0, 0, 2'b01, 0, 1, 0), "rst_seq", 1);
    apply(mk(1, 2'b01, 2'b00, 16'h00F1, 1, 1, 8'hF1, 0, 0, 2'b01, 0, 1, 0), "rst_seq", 2);
    apply(mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0), "rst_seq", 3);
    apply(mk(0, 2'b01, 2'b00, 16'h0060, 1, 0, 8'h00, 0, 0, 2'b00, 1, 0, 0), "rst_seq", 4);
    apply(mk(0, 2'b01, 2'b00, 16'h0060, 1, 1, 8'h60, 0, 0, 2'b01, 0, 1, 0), "rst_seq", 5);
    apply(mk(0, 2'b01, 2'b00, 16'h0061, 1, 1, 8'h61, 0, 0, 2'b01, 0, 1, 0), "rst_seq", 6);
    apply(mk(0, 2'b01, 2'b01, 16'h0062, 1, 1, 8'h62, 1, 0, 2'b01, 0, 1, 0), "rst_seq", 7);
    apply(mk(0, 2'b00, 2'b00, 16'h0000, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0), "rst_seq", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
